pipe_aluc: RTL

Registered ALU-control stage for the pipelined/multi-cycle MIPS datapath. It decodes aluop and the full 6-bit func into a widened ALU control code. It adds a valid/ready handshake and a one-entry output register. Multi-cycle MULT/DIV operations are sequenced with a busy counter, and a flush aborts them.

---
 rtl/aluc_pkg.sv | 29 ++
 rtl/aluc_decode.sv | 52 +++++
 rtl/pipe_aluc.sv | 103 ++++++++++
 3 files changed

// File: rtl/aluc_pkg.sv
// aluc_pkg: shared opcode, function-field, ALU-control and FSM-state definitions for pipe_aluc.
package aluc_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SLT = 2'b01;
  localparam logic [1:0] OP_R   = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  typedef enum logic [3:0] {
    AC_AND, AC_OR, AC_ADD, AC_XOR, AC_NOR, AC_ADDU, AC_SUB, AC_SLT,
    AC_SLTU, AC_SUBU, AC_SLL, AC_SRL, AC_SRA, AC_MULT, AC_DIV, AC_NOP
  } aluc_e;
  typedef enum logic {S_IDLE, S_BUSY} state_e;
endpackage

// File: rtl/aluc_decode.sv
// aluc_decode: combinational aluop/func to ALU-control decode with mult/div classification.
module aluc_decode
  import aluc_pkg::*;
#(
  parameter bit ENABLE_MD = 1'b1
) (
  input  logic [1:0] aluop,
  input  logic [5:0] func,
  output aluc_e      aluc,
  output logic       illegal,
  output logic       is_mult,
  output logic       is_div
);
  always_comb begin
    aluc = AC_NOP;
    illegal = 1'b0;
    is_mult = 1'b0;
    is_div = 1'b0;
    case (aluop)
      OP_ADD: aluc = AC_ADD;
      OP_SLT: aluc = AC_SLT;
      OP_SUB: aluc = AC_SUB;
      default:
        case (func)
          F_ADD:  aluc = AC_ADD;
          F_ADDU: aluc = AC_ADDU;
          F_SUB:  aluc = AC_SUB;
          F_SUBU: aluc = AC_SUBU;
          F_AND:  aluc = AC_AND;
          F_OR:   aluc = AC_OR;
          F_XOR:  aluc = AC_XOR;
          F_NOR:  aluc = AC_NOR;
          F_SLT:  aluc = AC_SLT;
          F_SLTU: aluc = AC_SLTU;
          F_SLL:  aluc = AC_SLL;
          F_SRL:  aluc = AC_SRL;
          F_SRA:  aluc = AC_SRA;
          F_MULT, F_MULTU: begin
            aluc = ENABLE_MD ? AC_MULT : AC_NOP;
            illegal = !ENABLE_MD;
            is_mult = ENABLE_MD;
          end
          F_DIV, F_DIVU: begin
            aluc = ENABLE_MD ? AC_DIV : AC_NOP;
            illegal = !ENABLE_MD;
            is_div = ENABLE_MD;
          end
          default: illegal = 1'b1;
        endcase
    endcase
  end
endmodule

// File: rtl/pipe_aluc.sv
// pipe_aluc: registered ALU-control stage with valid/ready output slot and multi-cycle mult/div sequencing.
module pipe_aluc
  import aluc_pkg::*;
#(
  parameter int ALUC_W      = 4,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter bit ENABLE_MD   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        aluop,
  input  logic [5:0]        func,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ALUC_W-1:0] aluc,
  output logic              illegal,
  output logic              md_start,
  output logic              md_busy,
  output logic              md_abort
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  aluc_e dec_aluc, aluc_q, aluc_d;
  logic dec_ill, dec_mult, dec_div, accept, md_acc;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic out_valid_q, out_valid_d, illegal_q, illegal_d, div_q, div_d;
  logic md_start_q, md_start_d, md_abort_q, md_abort_d;
  aluc_decode #(.ENABLE_MD(ENABLE_MD)) u_dec (
    .aluop(aluop), .func(func), .aluc(dec_aluc),
    .illegal(dec_ill), .is_mult(dec_mult), .is_div(dec_div)
  );
  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready) && !flush;
  assign accept = in_valid && in_ready;
  assign md_acc = accept && (dec_mult || dec_div);
  // Flush outranks everything; BUSY never overlaps a live output beat, so no accept check there.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    out_valid_d = out_valid_q && !out_ready;
    aluc_d = aluc_q;
    illegal_d = illegal_q;
    div_d = div_q;
    md_start_d = 1'b0;
    md_abort_d = 1'b0;
    if (flush) begin
      out_valid_d = 1'b0;
      if (state_q == S_BUSY) begin
        state_d = S_IDLE;
        cnt_d = '0;
        md_abort_d = 1'b1;
      end
    end else if (state_q == S_BUSY) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        state_d = S_IDLE;
        out_valid_d = 1'b1;
        aluc_d = div_q ? AC_DIV : AC_MULT;
        illegal_d = 1'b0;
      end
    end else if (md_acc) begin
      md_start_d = 1'b1;
      state_d = S_BUSY;
      cnt_d = dec_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      div_d = dec_div;
    end else if (accept) begin
      out_valid_d = 1'b1;
      aluc_d = dec_aluc;
      illegal_d = dec_ill;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      out_valid_q <= 1'b0;
      aluc_q <= AC_NOP;
      illegal_q <= 1'b0;
      div_q <= 1'b0;
      md_start_q <= 1'b0;
      md_abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      out_valid_q <= out_valid_d;
      aluc_q <= aluc_d;
      illegal_q <= illegal_d;
      div_q <= div_d;
      md_start_q <= md_start_d;
      md_abort_q <= md_abort_d;
    end
  end
  assign out_valid = out_valid_q;
  assign aluc = ALUC_W'(aluc_q);
  assign illegal = illegal_q;
  assign md_start = md_start_q;
  assign md_busy = (state_q == S_BUSY);
  assign md_abort = md_abort_q;
endmodule
